// File: rtl/approx_prod_accumulator.sv
// approx_prod_accumulator
//   Streaming dot-product accumulator placed after the unsigned 8x8 approximate
//   multipliers. Sums up to LEN products per vector, adds a constant BIAS with
//   every accepted term to offset the multipliers' mean underestimation, and
//   hands the result downstream over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   product beat valid
//   in_ready   accumulator can accept a beat
//   in_prod    unsigned product (PROD_W bits)
//   in_last    beat closes the vector (qualified by in_valid)
//   out_valid  result valid, held until accepted
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum including bias (ACC_W bits)
//   out_count  number of terms summed (1..LEN)
//   out_sat    saturation (SAT=1) or carry-out wrap (SAT=0) occurred in the vector
module approx_prod_accumulator #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN    = 8,
  parameter int unsigned BIAS   = 0,
  parameter int unsigned SAT    = 1,
  localparam int unsigned CW    = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CW-1:0]     out_count,
  output logic              out_sat
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W:0]   term;
  logic [ACC_W:0]   nxt;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    term    = {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod} + (ACC_W + 1)'(BIAS);
    nxt     = {1'b0, acc_q} + term;
    cnt_inc = cnt_q + 1'b1;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_ACC: begin
        if (in_valid && in_ready_q) begin
          // A saturated accumulator stays all-ones: any further nonzero term
          // carries out again, and a zero term leaves it unchanged.
          if (nxt[ACC_W]) begin
            flag_d = 1'b1;
            acc_d  = (SAT != 0) ? '1 : nxt[ACC_W-1:0];
          end else begin
            acc_d  = nxt[ACC_W-1:0];
          end
          cnt_d = cnt_inc;
          // in_last on the LEN-th beat is a single closure.
          if (in_last || (32'(cnt_inc) == LEN)) begin
            state_d     = ST_DONE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_ACC;
          acc_d       = '0;
          cnt_d       = '0;
          flag_d      = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_sat   = flag_q;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// tb_approx_prod_accumulator
//   Four accumulator instances share one input stream and run in lock-step
//   (acceptance timing does not depend on data):
//     a: defaults (ACC_W=24, BIAS=0, SAT=1)
//     b: BIAS=3
//     c: ACC_W=16, SAT=1 (clamp)
//     d: ACC_W=16, SAT=0 (wrap)
module tb_approx_prod_accumulator;

  typedef logic [15:0] beats_t [8];

  typedef struct {
    beats_t      p;
    int unsigned n;
    bit          last;
    logic [31:0] sum;
    logic [31:0] sumb;
    int unsigned cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, vld_a, sat_a;
  logic [23:0] sum_a;
  logic [3:0]  cnt_a;
  logic        rdy_b, vld_b, sat_b;
  logic [23:0] sum_b;
  logic [3:0]  cnt_b;
  logic        rdy_c, vld_c, sat_c;
  logic [15:0] sum_c;
  logic [3:0]  cnt_c;
  logic        rdy_d, vld_d, sat_d;
  logic [15:0] sum_d;
  logic [3:0]  cnt_d;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  approx_prod_accumulator u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready), .out_sum(sum_a),
    .out_count(cnt_a), .out_sat(sat_a));

  approx_prod_accumulator #(.BIAS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld_b), .out_ready(out_ready), .out_sum(sum_b),
    .out_count(cnt_b), .out_sat(sat_b));

  approx_prod_accumulator #(.ACC_W(16), .SAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_c), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready), .out_sum(sum_c),
    .out_count(cnt_c), .out_sat(sat_c));

  approx_prod_accumulator #(.ACC_W(16), .SAT(0)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_d), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld_d), .out_ready(out_ready), .out_sum(sum_d),
    .out_count(cnt_d), .out_sat(sat_d));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Presents one beat (after optional idle cycles) and returns just after the
  // edge that accepts it.
  task automatic send_beat(input logic [15:0] p, input logic last, input int unsigned max_idle);
    int unsigned w;
    repeat ($urandom_range(0, max_idle)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_prod  = 'x;
      in_last  = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    w = 0;
    while (!rdy_a && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (!rdy_a) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1 t=%0t", $time);
    end
    @(posedge clk);
  endtask

  task automatic send_vector(input beats_t p, input int unsigned n, input bit use_last,
                             input int unsigned max_idle);
    int unsigned w;
    for (int unsigned i = 0; i < n; i++) begin
      send_beat(p[i], (use_last && i == n - 1), max_idle);
      if (i != n - 1) begin
        #1 chk("early_out_valid", vld_a, 1'b0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_prod  = 'x;
    in_last  = 1'b0;
    chk("latency_out_valid", vld_a, 1'b1);
    w = 0;
    while (!vld_a && w < 20) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Expected values for the 16-bit instances derive from the exact total:
  // any carry-out happens iff the true sum reaches 2^16.
  task automatic check_all(input string nm, input logic [31:0] total, input logic [31:0] totb,
                           input int unsigned n);
    bit          ovf;
    logic [31:0] clamp, wrap;
    ovf   = (total >= 32'h1_0000);
    clamp = ovf ? 32'h0000_FFFF : total;
    wrap  = total & 32'h0000_FFFF;
    chk({nm, ":a_valid"}, vld_a, 1'b1);
    chk({nm, ":a_sum"},   sum_a, total);
    chk({nm, ":a_count"}, cnt_a, n);
    chk({nm, ":a_sat"},   sat_a, 1'b0);
    chk({nm, ":b_sum"},   sum_b, totb);
    chk({nm, ":b_count"}, cnt_b, n);
    chk({nm, ":b_sat"},   sat_b, 1'b0);
    chk({nm, ":c_sum"},   sum_c, clamp);
    chk({nm, ":c_sat"},   sat_c, ovf);
    chk({nm, ":d_sum"},   sum_d, wrap);
    chk({nm, ":d_sat"},   sat_d, ovf);
    chk({nm, ":d_count"}, cnt_d, n);
  endtask

  task automatic accept_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("accept_out_valid", vld_a, 1'b0);
    chk("accept_in_ready",  rdy_a, 1'b1);
  endtask

  vec_t        vt [7];
  beats_t      bp;
  int unsigned n;
  bit          ul;
  logic [31:0] total;

  initial begin
    vt[0].p = '{16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF};
    vt[0].n = 8; vt[0].last = 0; vt[0].sum = 32'h7F8;   vt[0].sumb = 32'h810;   vt[0].cnt = 8;
    vt[1].p = '{16'd10, 16'd20, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[1].n = 3; vt[1].last = 1; vt[1].sum = 32'd60;    vt[1].sumb = 32'd69;    vt[1].cnt = 3;
    vt[2].p = '{16'd100, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[2].n = 1; vt[2].last = 1; vt[2].sum = 32'd100;   vt[2].sumb = 32'd103;   vt[2].cnt = 1;
    vt[3].p = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    vt[3].n = 8; vt[3].last = 1; vt[3].sum = 32'd36;    vt[3].sumb = 32'd60;    vt[3].cnt = 8;
    vt[4].p = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[4].n = 2; vt[4].last = 1; vt[4].sum = 32'd0;     vt[4].sumb = 32'd6;     vt[4].cnt = 2;
    vt[5].p = '{16'hFFFF, 16'h0002, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    vt[5].n = 2; vt[5].last = 1; vt[5].sum = 32'h10001; vt[5].sumb = 32'h10007; vt[5].cnt = 2;
    vt[6].p = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    vt[6].n = 8; vt[6].last = 0; vt[6].sum = 32'h40000; vt[6].sumb = 32'h40018; vt[6].cnt = 8;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  rdy_a, 1'b1);
    chk("rst_out_valid", vld_a, 1'b0);
    chk("rst_out_sum",   sum_a, 0);
    chk("rst_out_count", cnt_a, 0);
    chk("rst_out_sat",   sat_a, 1'b0);
    rst_n = 1'b1;

    // Directed table: LEN closure, in_last closure, single term, coincident
    // in_last at LEN, zero products, clamp/wrap at 16 bits.
    for (int unsigned k = 0; k < 7; k++) begin
      send_vector(vt[k].p, vt[k].n, vt[k].last, 0);
      check_all($sformatf("vec%0d", k), vt[k].sum, vt[k].sumb, vt[k].cnt);
      accept_result();
    end

    // Held result under backpressure; beats offered meanwhile are not absorbed.
    bp = '{16'h0100, 16'h0200, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_vector(bp, 2, 1'b1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = 16'h1234;
    in_last  = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_out_valid", vld_a, 1'b1);
      chk("hold_out_sum",   sum_a, 32'h300);
      chk("hold_out_count", cnt_a, 2);
      chk("hold_in_ready",  rdy_a, 1'b0);
    end
    in_valid = 1'b0;
    accept_result();
    bp = '{16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_vector(bp, 1, 1'b1, 0);
    check_all("after_hold", 32'd5, 32'd8, 1);
    accept_result();

    // Reset mid-vector after 4 beats.
    for (int unsigned i = 0; i < 4; i++) send_beat(16'd50, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", vld_a, 1'b0);
    chk("midrst_out_sum",   sum_a, 0);
    chk("midrst_out_count", cnt_a, 0);
    chk("midrst_in_ready",  rdy_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    bp = '{16'd5, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_vector(bp, 2, 1'b1, 0);
    check_all("after_midrst", 32'd12, 32'd18, 2);

    // Reset while a result is held.
    #2 rst_n = 1'b0;
    #1;
    chk("donerst_out_valid", vld_a, 1'b0);
    chk("donerst_out_count", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random vectors with input idles and output backpressure.
    for (int unsigned v = 0; v < 200; v++) begin
      n     = $urandom_range(1, 8);
      ul    = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      total = 0;
      for (int unsigned i = 0; i < 8; i++) begin
        bp[i] = 16'($urandom);
        if (i < n) total += {16'd0, bp[i]};
      end
      send_vector(bp, n, ul, 2);
      check_all($sformatf("rnd%0d", v), total, total + 3 * n, n);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
